div_sched: RTL and testbench
============================

DIV_SCHED -- requirements
Module: div_sched

Interface
REQ-001 Parameter NREQ, default 4, SHALL set the number of requesters sharing one divider (2..8).
REQ-002 Parameter W, default 32, SHALL set the operand and result width.
REQ-003 Parameter TIMEOUT, default 64, SHALL set the maximum cycles spent waiting for div_done.
REQ-004 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 req  in  NREQ  per-requester request; operands SHALL be held stable by the requester until ack.
REQ-007 req_y / req_x  in  NREQ*W each  per-requester dividend / divisor, requester i in slice [i*W +: W].
REQ-008 ack  out  NREQ  one-cycle pulse, one-hot: the request was accepted.
REQ-009 rsp_valid, rsp_id[$clog2(NREQ)], rsp_q[W], rsp_r[W], rsp_err  out  result bus, shared.
REQ-010 rsp_ready  in  1  consumer accepts the result when high with rsp_valid.
REQ-011 busy  out  1  high in every state except IDLE.
REQ-012 div_en, div_y[W], div_x[W]  out  divider load strobe and operands.
REQ-013 div_q[W], div_r[W], div_done  in  divider results and one-cycle completion pulse.

Function
REQ-014 FSM states SHALL be IDLE, LOAD, WAIT, RESP.
REQ-015 IDLE: if any req bit is high, the round-robin winner SHALL be latched (id, y, x), its ack pulsed on the next cycle, and the FSM SHALL move to LOAD.
REQ-016 Round robin: search SHALL start at pointer p; after a grant to i, p SHALL become (i+1) mod NREQ.
REQ-017 LOAD: div_en=1 for exactly this one cycle with the latched div_y/div_x; the FSM SHALL then go to WAIT and clear the timeout counter.
REQ-018 WAIT: div_en=0; div_done=1 SHALL capture div_q/div_r and set rsp_err=0, then go to RESP.
REQ-019 WAIT: if the counter reaches TIMEOUT without div_done, the block SHALL go to RESP with rsp_q=0, rsp_r=0, rsp_err=1.
REQ-020 div_done outside WAIT SHALL be ignored.
REQ-021 RESP: rsp_valid=1, with id, q, r and err held stable; rsp_valid&&rsp_ready SHALL return the FSM to IDLE on the next cycle.
REQ-022 Minimum latency is req seen in IDLE at cycle N: ack at N+1 (LOAD), WAIT from N+2, RESP one cycle after div_done.
REQ-023 A req dropped before ack SHALL be dropped silently with no ack; a req raised during a busy state SHALL wait for IDLE.
REQ-024 req asserted in the same cycle rsp completes SHALL be arbitrated in the following IDLE cycle; there are no back-to-back grants without IDLE.
REQ-025 div_y/div_x SHALL hold the latched operands from LOAD through RESP.

Reset
REQ-026 rst_n low SHALL force IDLE immediately: ack=0, rsp_valid=0, rsp_err=0, rsp_q=0, rsp_r=0, rsp_id=0, div_en=0, div_y=0, div_x=0, p=0, counter=0, busy=0.
REQ-027 Reset mid-operation SHALL abandon the transfer with no response; div_done after reset release SHALL be ignored (REQ-020).

Configuration
REQ-028 With macro DIV_SCHED_DIVZERO_EN defined, a granted request with x==0 SHALL skip LOAD/WAIT: go IDLE->RESP with ack, rsp_q all ones, rsp_r=y, rsp_err=1, and no div_en.
REQ-029 Without the macro, x==0 SHALL go to the divider like any other request, and REQ-019 covers its termination.

Structure
REQ-030 Package div_sched_pkg SHALL hold the FSM state enum and the default constants for NREQ, W and TIMEOUT.
REQ-031 Sub-module rr_arbiter (req vector and pointer in, one-hot grant and index out, combinational) SHALL implement REQ-016.

Verification
REQ-032 Single request: req[0], y=100, x=7 -> ack[0] one cycle later; one div_en pulse; rsp q=14, r=2, id=0, err=0.
REQ-033 Contention: req=4'b1111 held with distinct operands -> grants in order 0,1,2,3, then 0 again if still requested.
REQ-034 Backpressure: rsp_ready=0 for 10 cycles in RESP -> rsp_* stable, busy=1, no new ack.
REQ-035 Timeout: divider model never pulses done -> RESP after 64 WAIT cycles, err=1, q=r=0.
REQ-036 Divide by zero, y=5, x=0 -> with DIV_SCHED_DIVZERO_EN: q=32'hFFFFFFFF, r=5, err=1, div_en never high; without the macro: the timeout path.
REQ-037 Reset pulsed in WAIT -> IDLE, all outputs 0, a late div_done produces no rsp_valid, next request served normally.

Source files
------------

// File: rtl/div_sched_pkg.sv
// -----------------------------------------------------------------------------
// div_sched_pkg
// Shared definitions for the divider scheduler: default parameter values,
// the scheduler FSM state type and a small index-wrapping helper used by the
// round-robin arbiter.
// -----------------------------------------------------------------------------
package div_sched_pkg;

    localparam int DEF_NREQ    = 4;
    localparam int DEF_W       = 32;
    localparam int DEF_TIMEOUT = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    // (base + off) mod n, used to walk requesters starting at the RR pointer.
    function automatic int wrap_idx(input int base, input int off, input int n);
        return (base + off) % n;
    endfunction

endpackage : div_sched_pkg

// File: rtl/div_sched_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick. The search starts at requester 'ptr' and
// wraps; the first asserted request wins.
//
// Ports:
//   req   [NREQ]  request vector
//   ptr   [IW]    index where the search starts
//   gnt   [NREQ]  one-hot grant (all zero when no request)
//   idx   [IW]    index of the granted requester
//   valid         at least one request is asserted
// -----------------------------------------------------------------------------
module rr_arbiter
    import div_sched_pkg::*;
#(
    parameter  int NREQ = DEF_NREQ,
    localparam int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   idx,
    output logic            valid
);

    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves
        // a value unassigned, which would otherwise infer a latch.
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!valid && req[IW'(wrap_idx(int'(ptr), k, NREQ))]) begin
                valid = 1'b1;
                idx   = IW'(wrap_idx(int'(ptr), k, NREQ));
                gnt[IW'(wrap_idx(int'(ptr), k, NREQ))] = 1'b1;
            end
        end
    end

endmodule : rr_arbiter

// File: rtl/div_sched.sv
// -----------------------------------------------------------------------------
// div_sched
// Shares one iterative divider between NREQ requesters. An IDLE cycle picks a
// round-robin winner and latches its operands; LOAD strobes the divider once;
// WAIT waits for div_done (bounded by TIMEOUT cycles); RESP holds the result
// until the consumer takes it. Exactly one transaction is in flight at a time
// and every grant is separated by at least one IDLE cycle.
//
// Optional feature: define DIV_SCHED_DIVZERO_EN to answer x==0 requests
// directly (q all ones, r = y, err = 1) without using the divider.
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   req [NREQ]               per-requester request (operands stable until ack)
//   req_y, req_x [NREQ*W]    per-requester dividend / divisor, slice [i*W +: W]
//   ack [NREQ]               one-cycle one-hot acceptance pulse
//   rsp_valid/id/q/r/err     shared result bus, held while in RESP
//   rsp_ready                consumer accepts the result
//   busy                     high whenever the FSM is not in IDLE
//   div_en, div_y, div_x     divider load strobe and operands
//   div_q, div_r, div_done   divider results and completion pulse
// -----------------------------------------------------------------------------
module div_sched
    import div_sched_pkg::*;
#(
    parameter  int NREQ    = DEF_NREQ,
    parameter  int W       = DEF_W,
    parameter  int TIMEOUT = DEF_TIMEOUT,
    localparam int IW      = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] req_y,
    input  logic [NREQ*W-1:0] req_x,
    output logic [NREQ-1:0]   ack,
    output logic              rsp_valid,
    output logic [IW-1:0]     rsp_id,
    output logic [W-1:0]      rsp_q,
    output logic [W-1:0]      rsp_r,
    output logic              rsp_err,
    input  logic              rsp_ready,
    output logic              busy,
    output logic              div_en,
    output logic [W-1:0]      div_y,
    output logic [W-1:0]      div_x,
    input  logic [W-1:0]      div_q,
    input  logic [W-1:0]      div_r,
    input  logic              div_done
);

    localparam int CW = $clog2(TIMEOUT + 1);

    state_t          state;
    logic [IW-1:0]   ptr;
    logic [CW-1:0]   cnt;

    logic [NREQ-1:0] arb_gnt;
    logic [IW-1:0]   arb_idx;
    logic            arb_valid;
    logic [W-1:0]    win_y;
    logic [W-1:0]    win_x;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req   (req),
        .ptr   (ptr),
        .gnt   (arb_gnt),
        .idx   (arb_idx),
        .valid (arb_valid)
    );

    assign win_y = req_y[arb_idx*W +: W];
    assign win_x = req_x[arb_idx*W +: W];

    assign busy = (state != ST_IDLE);

    // NOTE: all state below is written with non-blocking assignments so every
    // register samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            cnt       <= '0;
            ack       <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_q     <= '0;
            rsp_r     <= '0;
            rsp_err   <= 1'b0;
            div_en    <= 1'b0;
            div_y     <= '0;
            div_x     <= '0;
        end else begin
            // ack and div_en are single-cycle pulses.
            ack    <= '0;
            div_en <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (arb_valid) begin
                        ack    <= arb_gnt;
                        rsp_id <= arb_idx;
                        div_y  <= win_y;
                        div_x  <= win_x;
                        ptr    <= (arb_idx == IW'(NREQ - 1)) ? '0 : arb_idx + IW'(1);
`ifdef DIV_SCHED_DIVZERO_EN
                        if (win_x == '0) begin
                            rsp_q     <= '1;
                            rsp_r     <= win_y;
                            rsp_err   <= 1'b1;
                            rsp_valid <= 1'b1;
                            state     <= ST_RESP;
                        end else begin
                            div_en <= 1'b1;
                            state  <= ST_LOAD;
                        end
`else
                        div_en <= 1'b1;
                        state  <= ST_LOAD;
`endif
                    end
                end
                ST_LOAD: begin
                    cnt   <= '0;
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (div_done) begin
                        rsp_q     <= div_q;
                        rsp_r     <= div_r;
                        rsp_err   <= 1'b0;
                        rsp_valid <= 1'b1;
                        state     <= ST_RESP;
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        // This was the TIMEOUT-th WAIT cycle with no completion.
                        rsp_q     <= '0;
                        rsp_r     <= '0;
                        rsp_err   <= 1'b1;
                        rsp_valid <= 1'b1;
                        state     <= ST_RESP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule : div_sched

// File: tb/tb_div_sched.sv
// -----------------------------------------------------------------------------
// tb_div_sched
// Self-checking bench for div_sched with default parameters. A divider model
// answers each div_en after a chosen latency (or never, to force a timeout).
// Expected grants, results and latencies come from a reference model built
// from the round-robin and division rules.
// -----------------------------------------------------------------------------
module tb_div_sched;
    import div_sched_pkg::*;

    localparam int NREQ    = 4;
    localparam int W       = 32;
    localparam int TIMEOUT = 64;
    localparam int IW      = $clog2(NREQ);

    logic              clk;
    logic              rst_n;
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] req_y;
    logic [NREQ*W-1:0] req_x;
    logic [NREQ-1:0]   ack;
    logic              rsp_valid;
    logic [IW-1:0]     rsp_id;
    logic [W-1:0]      rsp_q;
    logic [W-1:0]      rsp_r;
    logic              rsp_err;
    logic              rsp_ready;
    logic              busy;
    logic              div_en;
    logic [W-1:0]      div_y;
    logic [W-1:0]      div_x;
    logic [W-1:0]      div_q;
    logic [W-1:0]      div_r;
    logic              div_done;

    div_sched #(.NREQ(NREQ), .W(W), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_y     (req_y),
        .req_x     (req_x),
        .ack       (ack),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_q     (rsp_q),
        .rsp_r     (rsp_r),
        .rsp_err   (rsp_err),
        .rsp_ready (rsp_ready),
        .busy      (busy),
        .div_en    (div_en),
        .div_y     (div_y),
        .div_x     (div_x),
        .div_q     (div_q),
        .div_r     (div_r),
        .div_done  (div_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Requester operands and reference-model state.
    logic [W-1:0] y_op [NREQ];
    logic [W-1:0] x_op [NREQ];
    int           ptr_m;

    // Divider model controls / observation.
    int div_lat  = 1;
    bit div_hang = 1'b0;
    int en_cnt   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_ops();
        for (int i = 0; i < NREQ; i++) begin
            req_y[i*W +: W] = y_op[i];
            req_x[i*W +: W] = x_op[i];
        end
    endtask

    // First requested index at or after p, wrapping.
    function automatic int rr_pick(input logic [NREQ-1:0] mask, input int p);
        for (int k = 0; k < NREQ; k++)
            if (mask[(p + k) % NREQ]) return (p + k) % NREQ;
        return -1;
    endfunction

    // Divider model: latches operands on div_en, pulses div_done div_lat
    // cycles later. A zero divisor or div_hang never completes. It is not
    // cleared by the scheduler's reset, so a stale completion can arrive late.
    initial begin
        int           dly;
        bit           pending;
        logic [W-1:0] my, mx;
        div_done = 1'b0;
        div_q    = '0;
        div_r    = '0;
        pending  = 1'b0;
        dly      = 0;
        my       = '0;
        mx       = '0;
        forever begin
            @(negedge clk);
            div_done = 1'b0;
            if (pending) begin
                dly--;
                if (dly == 0) begin
                    div_done = 1'b1;
                    div_q    = my / mx;
                    div_r    = my % mx;
                    pending  = 1'b0;
                end
            end
            if (div_en) begin
                en_cnt++;
                my      = div_y;
                mx      = div_x;
                dly     = div_lat;
                pending = !div_hang && (div_x != '0);
            end
        end
    end

    // One complete transaction. Called at a negedge with the DUT idle; returns
    // at the negedge after the response was accepted.
    task automatic txn(input logic [NREQ-1:0] mask, input int lat, input bit hang,
                       input int bp, input bit keep);
        int           w, n, exp_wait, exp_en;
        logic [W-1:0] eq, er;
        logic         eerr;
        div_lat  = lat;
        div_hang = hang;
        en_cnt   = 0;
        req      = mask;
        w        = rr_pick(mask, ptr_m);
        ptr_m    = (w + 1) % NREQ;
        if (x_op[w] == '0) begin
`ifdef DIV_SCHED_DIVZERO_EN
            eq = '1; er = y_op[w]; eerr = 1'b1; exp_wait = 0; exp_en = 0;
`else
            eq = '0; er = '0; eerr = 1'b1; exp_wait = TIMEOUT + 1; exp_en = 1;
`endif
        end else if (hang) begin
            eq = '0; er = '0; eerr = 1'b1; exp_wait = TIMEOUT + 1; exp_en = 1;
        end else begin
            eq = y_op[w] / x_op[w]; er = y_op[w] % x_op[w]; eerr = 1'b0;
            exp_wait = lat + 1; exp_en = 1;
        end

        @(negedge clk);
        check("ack_onehot", 64'(ack), 64'(1 << w));
        if (!keep) req[w] = 1'b0;

        n = 0;
        while (!rsp_valid && n < TIMEOUT + 40) begin
            @(negedge clk);
            n++;
        end
        check("rsp_latency", 64'(n), 64'(exp_wait));
        check("rsp_id", 64'(rsp_id), 64'(w));
        check("rsp_q", 64'(rsp_q), 64'(eq));
        check("rsp_r", 64'(rsp_r), 64'(er));
        check("rsp_err", 64'(rsp_err), 64'(eerr));
        check("div_en_count", 64'(en_cnt), 64'(exp_en));

        for (int c = 0; c < bp; c++) begin
            @(negedge clk);
            check("bp_ctrl", {rsp_valid, busy, ack, rsp_id, rsp_err},
                  {1'b1, 1'b1, NREQ'(0), IW'(w), eerr});
            check("bp_data", {rsp_q, rsp_r}, {eq, er});
        end

        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("accept_idle", {rsp_valid, busy}, 2'b00);
    endtask

    initial begin
        bit seen;
        rst_n     = 1'b0;
        req       = '0;
        req_y     = '0;
        req_x     = '0;
        rsp_ready = 1'b0;
        ptr_m     = 0;
        for (int i = 0; i < NREQ; i++) begin
            y_op[i] = '0;
            x_op[i] = 32'd1;
        end

        // Reset state.
        #12;
        check("reset_ctrl", {ack, rsp_valid, rsp_err, busy, div_en, rsp_id}, '0);
        check("reset_data", {rsp_q | rsp_r, div_y | div_x}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single request: 100 / 7.
        y_op[0] = 32'd100; x_op[0] = 32'd7; set_ops();
        txn(4'b0001, 3, 1'b0, 0, 1'b0);

        // Contention: all four held, distinct operands; expect 0,1,2,3,0.
        for (int i = 0; i < NREQ; i++) begin
            y_op[i] = $urandom;
            x_op[i] = 32'(i + 3);
        end
        set_ops();
        for (int t = 0; t < 5; t++)
            txn(4'b1111, $urandom_range(1, 6), 1'b0, 0, 1'b1);
        req = '0;
        @(negedge clk);

        // Backpressure with another requester waiting.
        y_op[2] = 32'd1000; x_op[2] = 32'd33; set_ops();
        txn(4'b0101, 2, 1'b0, 10, 1'b0);
        req = '0;
        @(negedge clk);

        // Timeout: divider never completes.
        y_op[1] = 32'd77; x_op[1] = 32'd5; set_ops();
        txn(4'b0010, 1, 1'b1, 0, 1'b0);

        // Divide by zero.
        y_op[3] = 32'd5; x_op[3] = 32'd0; set_ops();
        txn(4'b1000, 1, 1'b0, 1, 1'b0);

        // Randomized traffic.
        for (int t = 0; t < 10; t++) begin
            logic [NREQ-1:0] m;
            for (int i = 0; i < NREQ; i++) begin
                y_op[i] = $urandom;
                x_op[i] = $urandom >> $urandom_range(0, 31);
                if (x_op[i] == '0) x_op[i] = 32'd1;
            end
            set_ops();
            m = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            txn(m, $urandom_range(1, 12), 1'b0, $urandom_range(0, 3), 1'b0);
            req = '0;
            @(negedge clk);
        end

        // Reset in WAIT; the divider's late completion must be ignored.
        y_op[0] = 32'd900; x_op[0] = 32'd11; set_ops();
        div_lat  = 8;
        div_hang = 1'b0;
        req      = 4'b0001;
        w_for_reset: begin
            int w0;
            w0    = rr_pick(4'b0001, ptr_m);
            ptr_m = (w0 + 1) % NREQ;
            @(negedge clk);
            check("rst_test_ack", 64'(ack), 64'(1 << w0));
        end
        req = '0;
        @(negedge clk);
        @(negedge clk);
        check("rst_test_in_wait", {busy, rsp_valid}, 2'b10);
        rst_n = 1'b0;
        #1;
        ptr_m = 0;
        check("midrst_ctrl", {ack, rsp_valid, rsp_err, busy, div_en, rsp_id}, '0);
        check("midrst_data", {rsp_q | rsp_r, div_y | div_x}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (rsp_valid || busy) seen = 1'b1;
        end
        check("late_done_ignored", 64'(seen), 64'(0));

        // Served normally afterwards, pointer restarted at 0.
        y_op[0] = 32'd64; x_op[0] = 32'd8;
        y_op[3] = 32'd9;  x_op[3] = 32'd2; set_ops();
        txn(4'b1001, 2, 1'b0, 0, 1'b0);
        req = '0;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_div_sched
